multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Iterative multiply/divide unit for the Execute stage of the five-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU and returns the 64-bit {hi, lo} result.
- Drives `ok`, the multiply/divide-ready signal the hazard unit consumes: `ok` low stalls E, and while low the hazard unit does not flush E.
- Responds to the pipeline's advance and flush controls so a completed result is never recomputed or lost.

Parameters:
- MUL_STAGES, 1, cycles spent in the MUL state (1..4); the multiplier may be retimed across these stages.
- DIV_ITERS, 32, restoring-division iterations, one per cycle; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid  in  1  E-stage holds a mult/div instruction; held stable while ok=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; stable while valid
- a  in  32  rs operand (dividend / multiplicand); stable while valid
- b  in  32  rt operand (divisor / multiplier); stable while valid
- e_advance  in  1  E register loads a new instruction this cycle (=~stallE)
- flush  in  1  exception/eret flush of E; aborts any operation
- ok  out  1  0 = result not ready, stall E
- hi  out  32  result high word (product[63:32] / remainder)
- lo  out  32  result low word (product[31:0] / quotient)

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset (async) -> IDLE, cnt=0, hi=0, lo=0, operand regs=0.
- ok is combinational: 1 in DONE; 1 in IDLE when valid=0 or flush=1; 0 otherwise. It depends only on state, valid and flush, so there is no loop through e_advance.
- IDLE, valid=1, flush=0 (cycle 0): latch a, b and op at the clock edge.
  - op[1]=0 -> MUL, cnt=0.
  - op[1]=1 -> DIV, cnt=0.
  - Signed ops latch magnitudes plus the sign bits of a and b.
- MUL: cnt increments each cycle. At cnt==MUL_STAGES-1 write the full 64-bit product to {hi, lo} and go to DONE.
  - With default MUL_STAGES=1, DONE and ok=1 occur in cycle 2.
- MULT uses the 64-bit two's-complement product; MULTU uses the unsigned product.
- DIV: one restoring step per cycle on 32-bit magnitudes (shift remainder, trial subtract, set quotient bit). At cnt==DIV_ITERS-1:
  - apply sign correction: quotient negated if sign(a)!=sign(b); remainder takes sign(a);
  - write hi=remainder, lo=quotient;
  - go to DONE.
  - Iterations occupy cycles 1..32; DONE and ok=1 occur in cycle 33.
- Divide by zero (b==0), signed or unsigned: lo=32'hFFFFFFFF, hi=a (raw input). Latency is unchanged. No exception is raised.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- DONE: hi/lo held stable and ok=1.
  - e_advance=1 -> IDLE.
  - e_advance=0 -> stay in DONE with no restart, even though valid is still 1 (E stalled by the D-cache).
- hi/lo hold their last value in IDLE until the next completion.
- flush=1 in any state -> IDLE at the next edge; operation discarded; hi/lo unchanged. Flush has priority over start, completion and e_advance.
- A new instruction in E after the IDLE transition is started in the following cycle. Back-to-back ops therefore see one IDLE cycle with ok=0 before the MUL/DIV state.
- Operand changes while busy are ignored, since operands are latched.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> ok=0 in cycles 0–1, ok=1 in cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIVU a=100, b=7 -> ok=0 in cycles 0..32, ok=1 in cycle 33 with lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5, b=0 -> cycle 33: lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DONE hold: after DIVU 100/7 completes, keep valid=1 and e_advance=0 for 3 cycles -> ok stays 1, hi/lo stay 2/14, state stays DONE. Then e_advance=1 -> IDLE; ok=1 while valid=0.
- Flush mid-divide: start DIVU 100/7, assert flush in cycle 10 -> IDLE in cycle 11 with ok=1 (valid=0), hi/lo keep prior values. A subsequent MULTU 3*4 gives lo=12, hi=0 in cycle 2.
- Async reset asserted mid-MUL, between clock edges -> immediately IDLE with hi=lo=0. After deassertion with valid=0, ok=1; a new MULT 2*3 completes with lo=6 in cycle 2.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative MIPS multiply/divide unit for the Execute stage.
// The result is held in DONE until the pipeline advances E, or until a flush aborts the operation.
module multdiv_unit #(
  parameter int MUL_STAGES = 1,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        e_advance,
  input  logic        flush,
  output logic        ok,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] araw_q, araw_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;

  logic        in_sa, in_sb;
  logic [31:0] in_amag, in_bmag;
  logic [63:0] prod_mag, prod;
  logic [32:0] shifted;
  logic        take;
  logic [31:0] rem_next, quo_next, q_fix, r_fix;

  // Operand conditioning and datapath for one multiply result / one division step
  always_comb begin
    in_sa    = ~op[0] & a[31];
    in_sb    = ~op[0] & b[31];
    in_amag  = in_sa ? (32'd0 - a) : a;
    in_bmag  = in_sb ? (32'd0 - b) : b;
    prod_mag = {32'd0, a_q} * {32'd0, b_q};
    prod     = (sa_q ^ sb_q) ? (64'd0 - prod_mag) : prod_mag;
    // a_q doubles as the dividend/quotient shift register during DIV
    shifted  = {rem_q, a_q[31]};
    take     = (shifted >= {1'b0, b_q});
    rem_next = take ? (shifted[31:0] - b_q) : shifted[31:0];
    quo_next = {a_q[30:0], take};
    q_fix    = (sa_q ^ sb_q) ? (32'd0 - quo_next) : quo_next;
    r_fix    = sa_q ? (32'd0 - rem_next) : rem_next;
  end

  // Next-state logic; flush overrides everything and leaves hi/lo untouched
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    araw_d  = araw_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          a_d     = in_amag;
          b_d     = in_bmag;
          araw_d  = a;
          sa_d    = in_sa;
          sb_d    = in_sb;
          rem_d   = 32'd0;
          cnt_d   = 6'd0;
          state_d = op[1] ? S_DIV : S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == MUL_LAST) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 6'd1;
        a_d   = quo_next;
        rem_d = rem_next;
        if (cnt_q == DIV_LAST) begin
          if (b_q == 32'd0) begin
            hi_d = araw_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = r_fix;
            lo_d = q_fix;
          end
          state_d = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DONE: begin
        if (e_advance) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      araw_q  <= 32'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      araw_q  <= araw_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  // Ready flag: never a function of e_advance, so the hazard unit sees no loop
  always_comb begin
    if (state_q == S_DONE) begin
      ok = 1'b1;
    end else if (state_q == S_IDLE) begin
      ok = ~valid | flush;
    end else begin
      ok = 1'b0;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vectors, hand-written hold/flush/reset
// sequences, and randomized operations checked against an arithmetic reference model.
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        e_advance;
  logic        flush;
  logic        ok;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  multdiv_unit dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
    .e_advance(e_advance), .flush(flush), .ok(ok), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: MIPS semantics from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r, p;
    if (!o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    if (!o[1]) begin
      p = sx * sy;
      return 64'(p);
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one op, count cycles until ok, then advance E; returns latency and {hi,lo}
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [63:0] res);
    @(negedge clk);
    valid = 1'b1; op = o; a = x; b = y; e_advance = 1'b0; flush = 1'b0;
    lat = 0;
    #1;
    while (ok !== 1'b1 && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    res = {hi, lo};
    e_advance = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    e_advance = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic [63:0] prior;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 2};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 2};
    vecs[2] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 33};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 33};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         2};

    reset = 1'b1; valid = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    e_advance = 1'b0; flush = 1'b0;
    #1;
    check("reset_ok", {63'd0, ok}, 64'd1);
    check("reset_hilo", {hi, lo}, 64'd0);
    #11 reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_hilo", i), res, {vecs[i].hi, vecs[i].lo});
    end

    // DONE hold with E stalled, then advance
    @(negedge clk);
    valid = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    lat = 0;
    #1;
    while (ok !== 1'b1 && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("hold_lat", 64'(lat), 64'd33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold%0d_ok", i), {63'd0, ok}, 64'd1);
      check($sformatf("hold%0d_hilo", i), {hi, lo}, {32'd2, 32'd14});
    end
    e_advance = 1'b1; valid = 1'b0;
    @(negedge clk);
    e_advance = 1'b0;
    #1;
    check("adv_idle_ok", {63'd0, ok}, 64'd1);
    valid = 1'b1;
    #1;
    check("idle_valid_ok", {63'd0, ok}, 64'd0);
    valid = 1'b0;

    // Flush mid-divide
    do_op(2'b00, 32'd2, 32'd3, lat, prior);
    check("pre_flush_hilo", prior, 64'd6);
    @(negedge clk);
    valid = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; valid = 1'b0;
    #1;
    check("flush_cycle_ok", {63'd0, ok}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("post_flush_ok", {63'd0, ok}, 64'd1);
    check("post_flush_hilo", {hi, lo}, prior);
    repeat (30) @(negedge clk);
    #1;
    check("flush_late_ok", {63'd0, ok}, 64'd1);
    check("flush_late_hilo", {hi, lo}, prior);
    do_op(2'b01, 32'd3, 32'd4, lat, res);
    check("after_flush_lat", 64'(lat), 64'd2);
    check("after_flush_hilo", res, 64'd12);

    // Async reset between edges while in MUL
    @(negedge clk);
    valid = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'd0);
    valid = 1'b0;
    #1;
    check("async_rst_ok", {63'd0, ok}, 64'd1);
    #2 reset = 1'b0;
    do_op(2'b00, 32'd2, 32'd3, lat, res);
    check("after_rst_lat", 64'(lat), 64'd2);
    check("after_rst_hilo", res, 64'd6);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      do_op(ro, ra, rb, lat, res);
      check($sformatf("rnd%0d_lat", i), 64'(lat), ro[1] ? 64'd33 : 64'd2);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), res, model(ro, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
